// File: rtl/top_defines.vh
// rtl/top_defines.vh - shared AXI width and response-code macros
`ifndef TOP_DEFINES_VH
`define TOP_DEFINES_VH

`define AXI_ADDR_WIDTH 32
`define AXI_DATA_WIDTH 32
`define AXI_STRB_WIDTH 4

`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11

`endif

// File: rtl/dbus_axi_master.sv
// rtl/dbus_axi_master.sv - core data-bus to AXI4-lite master bridge, one access in flight
// DBUS_AXI_ERR_REPORT_EN enables reporting of non-OKAY BRESP/RRESP on rsp_err.
`include "top_defines.vh"

module dbus_axi_master #(
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [`AXI_ADDR_WIDTH-1:0]  req_addr,
    input  logic [`AXI_DATA_WIDTH-1:0]  req_wdata,
    input  logic [`AXI_STRB_WIDTH-1:0]  req_wstrb,
    output logic                        rsp_valid,
    output logic [`AXI_DATA_WIDTH-1:0]  rsp_rdata,
    output logic                        rsp_err,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [`AXI_ADDR_WIDTH-1:0]  AWADDR,
    output logic [2:0]                  AWPROT,
    output logic                        WVALID,
    input  logic                        WREADY,
    output logic [`AXI_DATA_WIDTH-1:0]  WDATA,
    output logic [`AXI_STRB_WIDTH-1:0]  WSTRB,
    input  logic                        BVALID,
    output logic                        BREADY,
    input  logic [1:0]                  BRESP,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    output logic [`AXI_ADDR_WIDTH-1:0]  ARADDR,
    output logic [2:0]                  ARPROT,
    input  logic                        RVALID,
    output logic                        RREADY,
    input  logic [`AXI_DATA_WIDTH-1:0]  RDATA,
    input  logic [1:0]                  RRESP
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t state;

    assign req_ready = (state == IDLE);
    assign AWPROT    = AXI_PROT;
    assign ARPROT    = AXI_PROT;

`ifndef DBUS_AXI_ERR_REPORT_EN
    logic unused_resp;
    assign unused_resp = ^{BRESP, RRESP};
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            AWVALID   <= 1'b0;
            AWADDR    <= '0;
            WVALID    <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            ARADDR    <= '0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef DBUS_AXI_ERR_REPORT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_we) begin
                            AWADDR  <= req_addr;
                            WDATA   <= req_wdata;
                            WSTRB   <= req_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            ARADDR  <= req_addr;
                            ARVALID <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // A channel whose VALID is already low has finished its handshake.
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                    if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
`ifdef DBUS_AXI_ERR_REPORT_EN
                        rsp_err   <= (BRESP != `AXI_RESP_OKAY);
`endif
                        state     <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= RDATA;
`ifdef DBUS_AXI_ERR_REPORT_EN
                        rsp_err   <= (RRESP != `AXI_RESP_OKAY);
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dbus_axi_master.md
# dbus_axi_master

AXI4-lite master bridge between the core's data-bus load/store port and the system AXI4-lite interconnect. Every peripheral register access, including the core timer, goes through this block. It converts one core request into exactly one AXI4-lite read or write transaction, with one transaction outstanding at a time. It returns the read data, plus an optional bus-error flag, to the core as a single-cycle response pulse.

## Interface
Parameters:
- AXI_PROT, default 3'b000: constant value driven on AWPROT/ARPROT.
- Widths come from top_defines.vh: `AXI_ADDR_WIDTH, `AXI_DATA_WIDTH, `AXI_STRB_WIDTH.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - ACLK  in  1  clock
  - ARESETn  in  1  asynchronous active-low reset
- Core request:
  - req_valid  in  1  core request present
  - req_ready  out  1  bridge idle, can accept a request
  - req_we  in  1  1=write, 0=read
  - req_addr  in  AXI_ADDR_WIDTH  byte address
  - req_wdata  in  AXI_DATA_WIDTH  write data
  - req_wstrb  in  AXI_STRB_WIDTH  byte enables (writes only)
- Core response:
  - rsp_valid  out  1  one-cycle completion pulse; the core always accepts it
  - rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes
  - rsp_err  out  1  nonzero BRESP/RRESP (see Configuration)
- AXI4-lite master channels:
  - AW: AWVALID out, AWREADY in, AWADDR out, AWPROT out
  - W: WVALID out, WREADY in, WDATA out, WSTRB out
  - B: BVALID in, BREADY out, BRESP in [1:0]
  - AR: ARVALID out, ARREADY in, ARADDR out, ARPROT out
  - R: RVALID in, RREADY out, RDATA in, RRESP in [1:0]

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/wdata/wstrb, then go to WR_REQ if req_we, else RD_REQ.
- WR_REQ:
  - AWVALID and WVALID are asserted together.
  - Each is dropped independently on its own READY handshake.
  - Once both handshakes are done, go to WR_RESP. Both may complete in the same cycle, or in either order.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BRESP and go to IDLE with rsp_valid pulsed.
- RD_REQ:
  - ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP:
  - RREADY=1.
  - On RVALID, capture RDATA/RRESP and go to IDLE with rsp_valid pulsed.
- AXI rules:
  - A VALID, once asserted, stays asserted until its READY.
  - Address/data/strobe stay stable while VALID is asserted.
  - No VALID depends combinationally on a READY.
  - All AXI outputs are registered.
- Requests arriving while not IDLE are not accepted (req_ready=0). The core holds its request.
- Addresses are passed through unmodified. The bridge performs no alignment checks.

## Timing
- Reset values: every output is 0 except req_ready, which is 1. AWPROT/ARPROT always equal AXI_PROT. FSM resets to IDLE.
- req_ready is decoded from state==IDLE.
- Minimum write latency, with a zero-wait slave:
  - Cycle 0: request accepted.
  - Cycle 1: AWVALID/WVALID high, handshakes complete.
  - Cycle 2: BREADY high, BVALID seen.
  - Cycle 3: rsp_valid=1 and req_ready=1.
- Minimum read latency: same shape. ARVALID in cycle 1, RREADY in cycle 2, rsp_valid in cycle 3.
- Each slave wait cycle adds exactly one cycle.
- rsp_valid is high for exactly one cycle. rsp_rdata/rsp_err hold their value until the next response.
- A new request can be accepted in the same cycle rsp_valid is high (back-to-back throughput of 3 cycles per access).
- Reset asserted mid-transaction: all outputs return to reset values immediately. The in-flight access is dropped with no response. The interconnect and slaves share ARESETn.

## Configuration
- Macro: DBUS_AXI_ERR_REPORT_EN.
- Defined: rsp_err = (captured BRESP/RRESP != 2'b00), registered alongside rsp_valid.
- Undefined: rsp_err is tied to 0 and the response codes are not stored. The port is present in both builds.

## Structure
- Shared header top_defines.vh holds:
  - the AXI width macros;
  - AXI_RESP_OKAY=2'b00, AXI_RESP_EXOKAY=2'b01, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
- FSM state encodings are localparams private to the module.
- Single module with no sub-module. The channel logic is too small to be worth splitting.

## Test plan
- Write, zero-wait slave: addr 0x0000_4000, wdata 0x0000_0064, wstrb 0xF.
  - AWADDR/WDATA/WSTRB match.
  - rsp_valid exactly 3 cycles after acceptance, rsp_rdata=0.
- Read, slave with 2-cycle ARREADY delay and 3-cycle RVALID delay, RDATA=0xDEAD_BEEF:
  - rsp_rdata=0xDEAD_BEEF.
  - rsp_valid 8 cycles after acceptance.
  - ARVALID is held stable throughout.
- Write with WREADY 2 cycles before AWREADY, and separately AWREADY before WREADY:
  - WVALID/AWVALID each drop individually on their handshake.
  - BREADY rises only after both handshakes.
- Back-to-back read then write, req_valid held high:
  - Second request is accepted in the rsp_valid cycle of the first.
  - No overlap of ARVALID and AWVALID.
- BRESP=2'b10:
  - With DBUS_AXI_ERR_REPORT_EN, rsp_err=1.
  - Without it, rsp_err=0.
- ARESETn pulsed low while in RD_RESP:
  - All outputs go to 0 and req_ready=1.
  - No rsp_valid.
  - The next read completes normally.
